ifu: RTL and testbench
======================

Name: ifu

Overview:
- Instruction fetch unit that sits directly upstream of the single-cycle core datapath.
- Takes the PC to fetch and issues one read to instruction memory over a valid/ready request and response handshake.
- Registers the returned word and presents it as the core's instruction input until the core accepts it.
- One fetch outstanding at a time; supports flush on redirect, a response timeout, and error reporting.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- TIMEOUT, 255, cycles spent in WAIT without a response before a timeout fault; legal range 1..65535.
- NOP_INST, 32'h00000013, instruction driven while no valid fetch is held (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- pc_valid  in  1  upstream PC offered.
- pc_ready  out  1  IFU can accept a PC.
- pc  in  XLEN  address to fetch.
- flush  in  1  discard the current fetch (redirect).
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  request address.
- mem_rsp_valid  in  1  read data returned.
- mem_rsp_ready  out  1  IFU accepts response.
- mem_rsp_data  in  XLEN  returned instruction.
- mem_rsp_err  in  1  memory access fault.
- inst_valid  out  1  inst holds a fetched word.
- inst_ready  in  1  core consumes inst this cycle.
- inst  out  XLEN  instruction to core.
- inst_pc  out  XLEN  PC of inst.
- fetch_err  out  1  inst is a faulted fetch; qualified by inst_valid.
- err_code  out  2  00 none, 01 bus fault, 10 timeout, 11 misaligned.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all valid outputs 0; inst=NOP_INST; inst_pc=0; fetch_err=0; err_code=00; timeout counter 0.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.

States:
- IDLE: pc_ready=1. On pc_valid, latch pc into addr and go to REQ.
- REQ: mem_req_valid=1 with addr held stable until mem_req_ready. On handshake, clear counter and go to WAIT.
- WAIT: mem_rsp_ready=1; counter increments each cycle.
  - On mem_rsp_valid: capture data, err and addr, then go to DONE.
  - If mem_rsp_err=1: inst=NOP_INST, fetch_err=1, code 01.
  - If counter reaches TIMEOUT with no response: go to DONE with inst=NOP_INST, fetch_err=1, code 10.
  - A response in the same cycle the counter reaches TIMEOUT wins (response accepted).
- DONE: inst_valid=1; inst, inst_pc and err are stable. On inst_ready, return to IDLE; inst_valid is low the next cycle.
- DRAIN: mem_rsp_ready=1. Discard the first mem_rsp_valid and go to IDLE. Counter runs; on TIMEOUT go to IDLE.

Latency and handshake:
- Minimum latency is pc handshake to inst_valid = 3 cycles, with mem_req_ready=1 and the response one cycle after the request.
- Throughput is one instruction per 4 cycles minimum. Back-to-back prefetch is out of scope.

Flush (highest priority, any state):
- In IDLE, REQ or DONE: go to IDLE, drop held data, inst_valid=0 next cycle. A not-yet-accepted request is withdrawn.
- In WAIT: go to DRAIN.
- flush takes priority over a pc_valid, inst_ready or mem_rsp_valid arriving in the same cycle.
- flush in the same cycle as mem_rsp_valid in WAIT: the response is consumed and discarded; go to IDLE, not DRAIN.

Other rules:
- mem_rsp_valid outside WAIT or DRAIN is ignored; mem_rsp_ready=0 in those states.
- Counter saturates at TIMEOUT; its width is $clog2(TIMEOUT+1).

Optional Feature:
- Macro IFU_ALIGN_CHECK_EN.
- When defined: a PC with pc[1:0]!=0 accepted in IDLE skips REQ and goes directly to DONE with inst=NOP_INST, fetch_err=1, code 11; no memory request is issued.
- When undefined: pc[1:0] is ignored, the full address is sent to memory, and code 11 is never produced.

Decomposition:
- Package ifu_pkg holds:
  - the state enum (IDLE, REQ, WAIT, DONE, DRAIN);
  - err_code constants ERR_NONE, ERR_BUS, ERR_TIMEOUT, ERR_MISALIGN;
  - the default NOP_INST constant.
- One sub-module, ifu_wdog: a clear/enable saturating counter with a reached-TIMEOUT flag, parameterised by TIMEOUT. It is reused in both WAIT and DRAIN.

Test Plan:
- Basic fetch: pc=0x80000000, mem_req_ready=1, response 1 cycle later with data 0x00100093 -> inst_valid on the 3rd cycle after the pc handshake; inst=0x00100093, inst_pc=0x80000000, fetch_err=0.
- Backpressure: hold mem_req_ready=0 for 5 cycles and inst_ready=0 for 4 cycles -> mem_req_addr stable throughout; inst stable and inst_valid=1 until inst_ready; no second request issued.
- Bus error and timeout:
  - mem_rsp_err=1 -> inst=0x00000013, err_code=01.
  - TIMEOUT=8 with no response -> inst_valid exactly 8 cycles after entering WAIT, err_code=10.
- Flush in WAIT: flush, then response 0xDEADBEEF 2 cycles later -> dropped; inst_valid never rises; pc_ready=1 the cycle after the response; the next fetch 0x80000004 returns correct data.
- Async reset mid-fetch: assert rst=0 between clock edges while in DONE -> inst_valid=0 and inst=0x00000013 immediately, without waiting for a clock; after release, the state is IDLE with pc_ready=1.
- With IFU_ALIGN_CHECK_EN, pc=0x80000002 -> no mem_req_valid ever; inst_valid 1 cycle later with err_code=11.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// error codes, the default NOP word and the state-to-handshake decode.
package ifu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } ifu_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BUS      = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_MISALIGN = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef struct packed {
        logic pc_ready;
        logic req_valid;
        logic rsp_ready;
        logic inst_valid;
    } ifu_ctrl_t;

    // Handshake outputs are a pure function of the state being entered.
    function automatic ifu_ctrl_t ctrl_of(input ifu_state_t s);
        ifu_ctrl_t c;
        c = '0;
        case (s)
            IDLE:    c.pc_ready   = 1'b1;
            REQ:     c.req_valid  = 1'b1;
            WAIT:    c.rsp_ready  = 1'b1;
            DONE:    c.inst_valid = 1'b1;
            DRAIN:   c.rsp_ready  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ifu_wdog.sv
// Saturating response watchdog for the fetch unit; hit_o flags the cycle in
// which the count reaches TIMEOUT while counting is enabled.
module ifu_wdog
    import ifu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIM    = CW'(TIMEOUT);
    localparam logic [CW-1:0] LIM_M1 = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the cycle whose increment lands on TIMEOUT, so the FSM leaves
    // WAIT exactly TIMEOUT cycles after entering it.
    assign hit_o = en_i && (cnt_q >= LIM_M1);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding read, flush/redirect, response
// timeout and fault reporting. Optional macro IFU_ALIGN_CHECK_EN enables
// misaligned-PC detection (error code 11, no memory request issued).
module ifu
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              TIMEOUT  = 255,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    output logic            mem_rsp_ready,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_err,
    output logic [1:0]      err_code
);

    ifu_state_t      state_q, state_d;
    ifu_ctrl_t       ctrl_q;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            fetch_err_q, fetch_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            wd_clr, wd_en, wd_hit;
    logic            misaligned;

`ifdef IFU_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // The watchdog restarts on request handshake and again when a flush
    // sends WAIT into DRAIN, so the drain gets a full TIMEOUT window.
    assign wd_en  = (state_q == WAIT) || (state_q == DRAIN);
    assign wd_clr = ((state_q == REQ) && mem_req_ready) ||
                    ((state_q == WAIT) && flush);

    ifu_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .hit_o (wd_hit)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        fetch_err_d = fetch_err_q;
        err_code_d  = err_code_q;
        case (state_q)
            IDLE: begin
                if (!flush && pc_valid) begin
                    addr_d = pc;
                    if (misaligned) begin
                        state_d     = DONE;
                        inst_d      = NOP_INST;
                        inst_pc_d   = pc;
                        fetch_err_d = 1'b1;
                        err_code_d  = ERR_MISALIGN;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response that lands with the flush is consumed here,
                // so there is nothing left to drain.
                if (flush) begin
                    state_d = mem_rsp_valid ? IDLE : DRAIN;
                end else if (mem_rsp_valid) begin
                    state_d     = DONE;
                    inst_pc_d   = addr_q;
                    fetch_err_d = mem_rsp_err;
                    err_code_d  = mem_rsp_err ? ERR_BUS : ERR_NONE;
                    inst_d      = mem_rsp_err ? NOP_INST : mem_rsp_data;
                end else if (wd_hit) begin
                    state_d     = DONE;
                    inst_pc_d   = addr_q;
                    fetch_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    inst_d      = NOP_INST;
                end
            end
            DONE: begin
                if (flush || inst_ready) begin
                    state_d     = IDLE;
                    inst_d      = NOP_INST;
                    fetch_err_d = 1'b0;
                    err_code_d  = ERR_NONE;
                end
            end
            DRAIN: begin
                if (mem_rsp_valid || wd_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ctrl_q      <= ctrl_of(IDLE);
            addr_q      <= '0;
            inst_q      <= NOP_INST;
            inst_pc_q   <= '0;
            fetch_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_of(state_d);
            addr_q      <= addr_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            fetch_err_q <= fetch_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign pc_ready      = ctrl_q.pc_ready;
    assign mem_req_valid = ctrl_q.req_valid;
    assign mem_rsp_ready = ctrl_q.rsp_ready;
    assign inst_valid    = ctrl_q.inst_valid;
    assign mem_req_addr  = addr_q;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign fetch_err     = fetch_err_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu built with TIMEOUT=8; covers fetch, backpressure,
// faults, flush, async reset and the optional alignment check.
module tb_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] pc;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic [1:0]  err_code;

    int checks;
    int failures;

    ifu #(
        .XLEN    (32),
        .TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_valid      (pc_valid),
        .pc_ready      (pc_ready),
        .pc            (pc),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .fetch_err     (fetch_err),
        .err_code      (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Advance past the next rising edge; outputs are then settled and inputs
    // written here are stable well before the following edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // From IDLE: hand over addr and let the request be accepted at once.
    task automatic go_to_wait(input logic [31:0] addr);
        pc            = addr;
        pc_valid      = 1'b1;
        mem_req_ready = 1'b1;
        cycle();
        pc_valid = 1'b0;
        cycle();
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        mem_rsp_err   = err;
        cycle();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
    endtask

    task automatic accept();
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pc_valid = 1'b1;
        pc = 32'h8000_0000;
        cycle();
        cycle();
        checks++;
        if ({pc_ready, mem_req_valid, mem_rsp_ready, inst_valid, fetch_err} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 10000", {pc_ready, mem_req_valid, mem_rsp_ready, inst_valid, fetch_err});
        end
        checks++;
        if (inst !== NOP) begin
            failures++;
            $display("FAIL reset_inst: got %h want %h", inst, NOP);
        end
        checks++;
        if (inst_pc !== 32'h0 || err_code !== 2'b00) begin
            failures++;
            $display("FAIL reset_pc_code: got %h/%b want 0/00", inst_pc, err_code);
        end
        pc_valid = 1'b0;
        rst = 1'b1;
        cycle();
        checks++;
        if (pc_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got ready=%b req=%b want 1/0", pc_ready, mem_req_valid);
        end
    endtask

    task automatic test_basic();
        pc            = 32'h8000_0000;
        pc_valid      = 1'b1;
        mem_req_ready = 1'b1;
        cycle();
        pc_valid = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || pc_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_req: got v=%b a=%h r=%b want 1/80000000/0", mem_req_valid, mem_req_addr, pc_ready);
        end
        cycle();
        checks++;
        if (mem_rsp_ready !== 1'b1 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_wait: got rsp_rdy=%b req=%b iv=%b want 1/0/0", mem_rsp_ready, mem_req_valid, inst_valid);
        end
        respond(32'h0010_0093, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0010_0093) begin
            failures++;
            $display("FAIL basic_inst: got iv=%b inst=%h want 1/00100093", inst_valid, inst);
        end
        checks++;
        if (inst_pc !== 32'h8000_0000 || fetch_err !== 1'b0 || err_code !== 2'b00) begin
            failures++;
            $display("FAIL basic_meta: got pc=%h e=%b c=%b want 80000000/0/00", inst_pc, fetch_err, err_code);
        end
        accept();
        checks++;
        if (inst_valid !== 1'b0 || pc_ready !== 1'b1 || inst !== NOP) begin
            failures++;
            $display("FAIL basic_accept: got iv=%b rdy=%b inst=%h want 0/1/%h", inst_valid, pc_ready, inst, NOP);
        end
    endtask

    task automatic test_backpressure();
        pc            = 32'h8000_0010;
        pc_valid      = 1'b1;
        mem_req_ready = 1'b0;
        cycle();
        pc_valid = 1'b0;
        pc       = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010) begin
                failures++;
                $display("FAIL bp_req_hold[%0d]: got v=%b a=%h want 1/80000010", i, mem_req_valid, mem_req_addr);
            end
        end
        mem_req_ready = 1'b1;
        cycle();
        respond(32'h0020_0113, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h0020_0113 || mem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL bp_inst_hold[%0d]: got iv=%b inst=%h req=%b want 1/00200113/0", i, inst_valid, inst, mem_req_valid);
            end
        end
        accept();
        checks++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_after: got iv=%b req=%b want 0/0", inst_valid, mem_req_valid);
        end
    endtask

    task automatic test_bus_err();
        go_to_wait(32'h8000_0020);
        respond(32'hFFFF_FFFF, 1'b1);
        checks++;
        if ({inst_valid, fetch_err, err_code} !== 4'b1101 || inst !== NOP) begin
            failures++;
            $display("FAIL bus_err: got iv/e/c=%b inst=%h want 1101/%h", {inst_valid, fetch_err, err_code}, inst, NOP);
        end
        checks++;
        if (inst_pc !== 32'h8000_0020) begin
            failures++;
            $display("FAIL bus_err_pc: got %h want 80000020", inst_pc);
        end
        accept();
    endtask

    task automatic test_timeout();
        go_to_wait(32'h8000_0030);
        for (int k = 1; k < 8; k++) begin
            cycle();
            checks++;
            if (inst_valid !== 1'b0 || mem_rsp_ready !== 1'b1) begin
                failures++;
                $display("FAIL tmo_early[%0d]: got iv=%b rsp_rdy=%b want 0/1", k, inst_valid, mem_rsp_ready);
            end
        end
        cycle();
        checks++;
        if ({inst_valid, fetch_err, err_code} !== 4'b1110 || inst !== NOP) begin
            failures++;
            $display("FAIL tmo_fire: got iv/e/c=%b inst=%h want 1110/%h", {inst_valid, fetch_err, err_code}, inst, NOP);
        end
        checks++;
        if (inst_pc !== 32'h8000_0030) begin
            failures++;
            $display("FAIL tmo_pc: got %h want 80000030", inst_pc);
        end
        accept();
        // Response arriving on the very cycle the count hits TIMEOUT wins.
        go_to_wait(32'h8000_0060);
        repeat (7) cycle();
        respond(32'h0040_8213, 1'b0);
        checks++;
        if ({inst_valid, fetch_err, err_code} !== 4'b1000 || inst !== 32'h0040_8213) begin
            failures++;
            $display("FAIL tmo_tie: got iv/e/c=%b inst=%h want 1000/00408213", {inst_valid, fetch_err, err_code}, inst);
        end
        accept();
    endtask

    task automatic test_flush_wait();
        go_to_wait(32'h8000_0040);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (pc_ready !== 1'b0 || mem_rsp_ready !== 1'b1 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drain: got rdy=%b rsp_rdy=%b iv=%b want 0/1/0", pc_ready, mem_rsp_ready, inst_valid);
        end
        cycle();
        respond(32'hDEAD_BEEF, 1'b0);
        checks++;
        if (pc_ready !== 1'b1 || inst_valid !== 1'b0 || mem_rsp_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop: got rdy=%b iv=%b rsp_rdy=%b want 1/0/0", pc_ready, inst_valid, mem_rsp_ready);
        end
        cycle();
        checks++;
        if (inst_valid !== 1'b0 || inst !== NOP) begin
            failures++;
            $display("FAIL flush_quiet: got iv=%b inst=%h want 0/%h", inst_valid, inst, NOP);
        end
        go_to_wait(32'h8000_0004);
        respond(32'h0030_8193, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0030_8193 || inst_pc !== 32'h8000_0004) begin
            failures++;
            $display("FAIL flush_refetch: got iv=%b inst=%h pc=%h want 1/00308193/80000004", inst_valid, inst, inst_pc);
        end
        accept();
    endtask

    task automatic test_flush_misc();
        pc            = 32'h8000_0050;
        pc_valid      = 1'b1;
        mem_req_ready = 1'b0;
        cycle();
        pc_valid = 1'b0;
        flush    = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || pc_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_req: got req=%b rdy=%b want 0/1", mem_req_valid, pc_ready);
        end
        go_to_wait(32'h8000_0054);
        flush = 1'b1;
        respond(32'h1111_1111, 1'b0);
        flush = 1'b0;
        checks++;
        if (pc_ready !== 1'b1 || mem_rsp_ready !== 1'b0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_rsp_same: got rdy=%b rsp_rdy=%b iv=%b want 1/0/0", pc_ready, mem_rsp_ready, inst_valid);
        end
        go_to_wait(32'h8000_0058);
        respond(32'h2222_2222, 1'b0);
        flush      = 1'b1;
        inst_ready = 1'b1;
        cycle();
        flush      = 1'b0;
        inst_ready = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || inst !== NOP || pc_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_done: got iv=%b inst=%h rdy=%b want 0/%h/1", inst_valid, inst, pc_ready, NOP);
        end
        pc       = 32'h8000_005C;
        pc_valid = 1'b1;
        flush    = 1'b1;
        cycle();
        pc_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (pc_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_pc: got rdy=%b req=%b want 1/0", pc_ready, mem_req_valid);
        end
    endtask

    task automatic test_async_reset();
        go_to_wait(32'h8000_0070);
        respond(32'h0050_0293, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0050_0293) begin
            failures++;
            $display("FAIL areset_pre: got iv=%b inst=%h want 1/00500293", inst_valid, inst);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || inst !== NOP || fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL areset_now: got iv=%b inst=%h e=%b want 0/%h/0", inst_valid, inst, fetch_err, NOP);
        end
        #2;
        rst = 1'b1;
        cycle();
        checks++;
        if (pc_ready !== 1'b1 || inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_after: got rdy=%b iv=%b req=%b want 1/0/0", pc_ready, inst_valid, mem_req_valid);
        end
    endtask

    task automatic test_align();
        pc            = 32'h8000_0002;
        pc_valid      = 1'b1;
        mem_req_ready = 1'b1;
        cycle();
        pc_valid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        checks++;
        if ({inst_valid, fetch_err, err_code} !== 4'b1111 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL align_trap: got iv/e/c=%b req=%b want 1111/0", {inst_valid, fetch_err, err_code}, mem_req_valid);
        end
        checks++;
        if (inst !== NOP || inst_pc !== 32'h8000_0002) begin
            failures++;
            $display("FAIL align_data: got inst=%h pc=%h want %h/80000002", inst, inst_pc, NOP);
        end
        accept();
        checks++;
        if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL align_noreq: got req=%b iv=%b want 0/0", mem_req_valid, inst_valid);
        end
`else
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0002) begin
            failures++;
            $display("FAIL align_off_req: got v=%b a=%h want 1/80000002", mem_req_valid, mem_req_addr);
        end
        cycle();
        respond(32'h0060_0313, 1'b0);
        checks++;
        if ({inst_valid, fetch_err, err_code} !== 4'b1000 || inst !== 32'h0060_0313) begin
            failures++;
            $display("FAIL align_off_rsp: got iv/e/c=%b inst=%h want 1000/00600313", {inst_valid, fetch_err, err_code}, inst);
        end
        accept();
`endif
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        pc_valid      = 1'b0;
        pc            = 32'h0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b0;
        inst_ready    = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_bus_err();
        test_timeout();
        test_flush_wait();
        test_flush_misc();
        test_async_reset();
        test_align();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
